// File: rtl/d_e_reg_pkg.sv
// Shared pipeline constants for the decode->execute boundary.
//   - ALU operation encodings used by the E stage
//   - Tnew width and type
//   - Default PC carried by a bubble or by reset
//   - Packed record of everything latched between D and E, plus helpers
package d_e_reg_pkg;

    localparam int          TNEW_W           = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [4:0] {
        ALU_AND = 5'd0,
        ALU_OR  = 5'd1,
        ALU_ADD = 5'd2,
        ALU_SUB = 5'd3
    } alu_op_e;

    typedef logic [TNEW_W-1:0] tnew_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  aluop;
        logic        alusrc;
        logic        regwrite;
        logic [4:0]  a3;
        tnew_t       tnew;
    } de_fields_t;

    // A bubble is an all-zero record except for the PC it carries.
    function automatic de_fields_t bubble(input logic [31:0] pc);
        de_fields_t f;
        f    = '0;
        f.pc = pc;
        return f;
    endfunction

    // One stage has elapsed between D and E; saturate so 0 never wraps to 3.
    function automatic tnew_t tnew_age(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

endpackage

// File: rtl/d_e_reg_if.sv
// Bundle of the D->E pipeline register signals.
//   master : drives en/clr, the D_* stage inputs and the M/W forwarding
//            sources; observes the E_* outputs
//   slave  : the pipeline register itself
interface d_e_reg_if;
    import d_e_reg_pkg::*;

    logic        en;
    logic        clr;

    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [31:0] D_EXT;
    logic [4:0]  D_ALUOp;
    logic        D_ALUSrc;
    logic        D_RegWrite;
    logic [4:0]  D_A3;
    tnew_t       D_Tnew;

    logic [4:0]  M_A3;
    logic        M_RegWrite;
    tnew_t       M_Tnew;
    logic [31:0] M_WD;
    logic [4:0]  W_A3;
    logic        W_RegWrite;
    logic [31:0] W_WD;

    logic [31:0] E_PC;
    logic [31:0] E_Instr;
    logic [4:0]  E_ALUOp;
    logic        E_RegWrite;
    logic [4:0]  E_A3;
    tnew_t       E_Tnew;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic [31:0] E_RT;

    modport master (
        output en, clr,
        output D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_ALUOp, D_ALUSrc,
               D_RegWrite, D_A3, D_Tnew,
        output M_A3, M_RegWrite, M_Tnew, M_WD, W_A3, W_RegWrite, W_WD,
        input  E_PC, E_Instr, E_ALUOp, E_RegWrite, E_A3, E_Tnew,
               E_A, E_B, E_RT
    );

    modport slave (
        input  en, clr,
        input  D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_ALUOp, D_ALUSrc,
               D_RegWrite, D_A3, D_Tnew,
        input  M_A3, M_RegWrite, M_Tnew, M_WD, W_A3, W_RegWrite, W_WD,
        output E_PC, E_Instr, E_ALUOp, E_RegWrite, E_A3, E_Tnew,
               E_A, E_B, E_RT
    );

endinterface

// File: rtl/d_e_reg_fwd_mux.sv
// Operand forwarding mux for one source register in the E stage.
//   rnum                 : source register number decoded from E instruction
//   reg_val              : value read from the register file in D
//   m_a3/m_regwrite/m_tnew/m_wd : M-stage producer
//   w_a3/w_regwrite/w_wd        : W-stage producer
//   fwd_val              : freshest available value for rnum
// M beats W because it is the younger producer. M is only usable once its
// result is ready (Tnew==0); if it is not ready the hazard unit has already
// stalled, so W/register values seen here in that case are don't-care.
module e_fwd_mux
    import d_e_reg_pkg::*;
(
    input  logic [4:0]  rnum,
    input  logic [31:0] reg_val,
    input  logic [4:0]  m_a3,
    input  logic        m_regwrite,
    input  tnew_t       m_tnew,
    input  logic [31:0] m_wd,
    input  logic [4:0]  w_a3,
    input  logic        w_regwrite,
    input  logic [31:0] w_wd,
    output logic [31:0] fwd_val
);

    always_comb begin
        fwd_val = reg_val;
        // $0 is hard-wired to zero and must never pick up a forwarded value.
        if (rnum != 5'd0) begin
            if (m_regwrite && (m_a3 == rnum) && (m_tnew == '0)) begin
                fwd_val = m_wd;
            end else if (w_regwrite && (w_a3 == rnum)) begin
                fwd_val = w_wd;
            end
        end
    end

endmodule

// File: rtl/d_e_reg.sv
// D->E pipeline register with E-stage operand forwarding.
//   clk   : rising-edge clock
//   reset : synchronous active-high; loads a bubble (PC = RESET_PC)
//   bus   : d_e_reg_if.slave -- en/clr control, D_* fields in, M/W
//           forwarding sources in, E_* fields and forwarded operands out
// Edge priority: reset > clr > hold (en=0) > load (en=1).
module d_e_reg
    import d_e_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic     clk,
    input  logic     reset,
    d_e_reg_if.slave bus
);

    de_fields_t fields_reg;
    de_fields_t fields_next;

    always_comb begin
        fields_next = fields_reg;
        if (bus.clr) begin
            fields_next = bubble(RESET_PC);
        end else if (bus.en) begin
            fields_next.pc       = bus.D_PC;
            fields_next.instr    = bus.D_Instr;
            fields_next.rd1      = bus.D_RD1;
            fields_next.rd2      = bus.D_RD2;
            fields_next.ext      = bus.D_EXT;
            fields_next.aluop    = bus.D_ALUOp;
            fields_next.alusrc   = bus.D_ALUSrc;
            fields_next.regwrite = bus.D_RegWrite;
            fields_next.a3       = bus.D_A3;
            fields_next.tnew     = tnew_age(bus.D_Tnew);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fields_reg <= bubble(RESET_PC);
        end else begin
            fields_reg <= fields_next;
        end
    end

    // Index 0 = rs, index 1 = rt.
    logic [4:0]  src_num [2];
    logic [31:0] src_reg [2];
    logic [31:0] src_fwd [2];

    assign src_num[0] = fields_reg.instr[25:21];
    assign src_num[1] = fields_reg.instr[20:16];
    assign src_reg[0] = fields_reg.rd1;
    assign src_reg[1] = fields_reg.rd2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            e_fwd_mux u_fwd (
                .rnum       (src_num[gi]),
                .reg_val    (src_reg[gi]),
                .m_a3       (bus.M_A3),
                .m_regwrite (bus.M_RegWrite),
                .m_tnew     (bus.M_Tnew),
                .m_wd       (bus.M_WD),
                .w_a3       (bus.W_A3),
                .w_regwrite (bus.W_RegWrite),
                .w_wd       (bus.W_WD),
                .fwd_val    (src_fwd[gi])
            );
        end
    endgenerate

    assign bus.E_PC       = fields_reg.pc;
    assign bus.E_Instr    = fields_reg.instr;
    assign bus.E_ALUOp    = fields_reg.aluop;
    assign bus.E_RegWrite = fields_reg.regwrite;
    assign bus.E_A3       = fields_reg.a3;
    assign bus.E_Tnew     = fields_reg.tnew;
    assign bus.E_A        = src_fwd[0];
    assign bus.E_RT       = src_fwd[1];
    assign bus.E_B        = fields_reg.alusrc ? fields_reg.ext : src_fwd[1];

endmodule

// File: tb/tb_d_e_reg.sv
// Self-checking bench for d_e_reg. Each scenario task pushes the E-stage
// values it expects onto a queue as it drives stimulus, then pops and
// compares once the register (or the forwarding mux) has produced them.
module tb_d_e_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  aluop;
        logic        regwrite;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rt;
    } eobs_t;

    localparam logic [31:0] BUBBLE_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    eobs_t exp_q[$];

    d_e_reg_if bus();

    d_e_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic eobs_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [4:0] aluop, input logic rw,
                                 input logic [4:0] a3, input logic [1:0] tnew,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rt);
        eobs_t e;
        e.pc = pc; e.instr = instr; e.aluop = aluop; e.regwrite = rw;
        e.a3 = a3; e.tnew = tnew; e.a = a; e.b = b; e.rt = rt;
        return e;
    endfunction

    function automatic eobs_t sample();
        return mk(bus.E_PC, bus.E_Instr, bus.E_ALUOp, bus.E_RegWrite,
                  bus.E_A3, bus.E_Tnew, bus.E_A, bus.E_B, bus.E_RT);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.clr = 1'b0;
        bus.D_PC = '0; bus.D_Instr = '0; bus.D_RD1 = '0; bus.D_RD2 = '0;
        bus.D_EXT = '0; bus.D_ALUOp = '0; bus.D_ALUSrc = 1'b0;
        bus.D_RegWrite = 1'b0; bus.D_A3 = '0; bus.D_Tnew = '0;
        bus.M_A3 = '0; bus.M_RegWrite = 1'b0; bus.M_Tnew = '0; bus.M_WD = '0;
        bus.W_A3 = '0; bus.W_RegWrite = 1'b0; bus.W_WD = '0;
    endtask

    task automatic drive_d(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] ext, input logic [4:0] aluop,
                           input logic alusrc, input logic rw,
                           input logic [4:0] a3, input logic [1:0] tnew);
        bus.D_PC = pc; bus.D_Instr = instr; bus.D_RD1 = rd1; bus.D_RD2 = rd2;
        bus.D_EXT = ext; bus.D_ALUOp = aluop; bus.D_ALUSrc = alusrc;
        bus.D_RegWrite = rw; bus.D_A3 = a3; bus.D_Tnew = tnew;
    endtask

    task automatic test_reset();
        eobs_t obs, exp;
        idle_inputs();
        reset = 1'b1;
        bus.en = 1'b1;
        drive_d(32'h0000_5000, 32'h1234_5678, 32'h1, 32'h2, 32'h3, 5'd2, 1'b1, 1'b1, 5'd7, 2'd2);
        exp_q.push_back(mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0));
        tick();
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        reset = 1'b0;
        bus.en = 1'b0;
        $display("reset: E_PC=%h E_Instr=%h", obs.pc, obs.instr);
    endtask

    task automatic test_load();
        eobs_t obs, exp;
        // ori $2, $1, 5 : rs=1 rt=2, immediate operand
        bus.en = 1'b1;
        drive_d(32'h0000_3004, 32'h3422_0005, 32'h100, 32'h200, 32'h5,
                5'd1, 1'b1, 1'b1, 5'd2, 2'd2);
        exp_q.push_back(mk(32'h3004, 32'h3422_0005, 5'd1, 1'b1, 5'd2, 2'd1,
                           32'h100, 32'h5, 32'h200));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL load_ori: got %h expected %h", obs, exp);
        end
        $display("load ori: E_PC=%h E_B=%h E_Tnew=%0d", obs.pc, obs.b, obs.tnew);

        // register-register op: E_B follows rt, Tnew 3 ages to 2
        drive_d(32'h0000_3008, 32'h0022_1820, 32'h7, 32'h9, 32'hdead,
                5'd2, 1'b0, 1'b1, 5'd3, 2'd3);
        exp_q.push_back(mk(32'h3008, 32'h0022_1820, 5'd2, 1'b1, 5'd3, 2'd2,
                           32'h7, 32'h9, 32'h9));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL load_rr: got %h expected %h", obs, exp);
        end
        $display("load add: E_A=%h E_B=%h E_Tnew=%0d", obs.a, obs.b, obs.tnew);
        bus.en = 1'b0;
    endtask

    task automatic test_stall();
        eobs_t obs, exp, held;
        bus.en = 1'b1;
        drive_d(32'h0000_300c, 32'h0043_2022, 32'h40, 32'h50, 32'h60,
                5'd3, 1'b0, 1'b1, 5'd4, 2'd1);
        held = mk(32'h300c, 32'h0043_2022, 5'd3, 1'b1, 5'd4, 2'd0,
                  32'h40, 32'h50, 32'h50);
        exp_q.push_back(held);
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_load: got %h expected %h", obs, exp);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_d($urandom, $urandom, $urandom, $urandom, $urandom,
                    5'($urandom), 1'($urandom), 1'b1, 5'($urandom), 2'($urandom));
            exp_q.push_back(held);
            tick();
            obs = sample(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, obs, exp);
            end
            $display("stall cycle %0d: E_PC=%h", i, obs.pc);
        end
        bus.clr = 1'b1;
        exp_q.push_back(mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_clr: got %h expected %h", obs, exp);
        end
        $display("clr after stall: E_PC=%h E_Instr=%h", obs.pc, obs.instr);
        bus.clr = 1'b0;
    endtask

    task automatic test_forward();
        eobs_t obs, exp;
        // rs=3, rt=4, rd=5
        bus.en = 1'b1;
        drive_d(32'h0000_3010, 32'h0064_2800, 32'haaaa, 32'hbbbb, 32'h7,
                5'd2, 1'b0, 1'b1, 5'd5, 2'd1);
        tick();
        bus.en = 1'b0;

        bus.M_A3 = 5'd3; bus.M_RegWrite = 1'b1; bus.M_Tnew = 2'd0; bus.M_WD = 32'h11;
        bus.W_A3 = 5'd3; bus.W_RegWrite = 1'b1; bus.W_WD = 32'h22;
        exp_q.push_back(mk(32'h3010, 32'h0064_2800, 5'd2, 1'b1, 5'd5, 2'd0,
                           32'h11, 32'hbbbb, 32'hbbbb));
        #1;
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_m_over_w: got %h expected %h", obs, exp);
        end
        $display("fwd M+W match: E_A=%h", obs.a);

        bus.M_RegWrite = 1'b0;
        exp_q.push_back(mk(32'h3010, 32'h0064_2800, 5'd2, 1'b1, 5'd5, 2'd0,
                           32'h22, 32'hbbbb, 32'hbbbb));
        #1;
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_w: got %h expected %h", obs, exp);
        end
        $display("fwd W only: E_A=%h", obs.a);

        // M matches but result not ready yet: falls through to W
        bus.M_RegWrite = 1'b1; bus.M_Tnew = 2'd1;
        exp_q.push_back(mk(32'h3010, 32'h0064_2800, 5'd2, 1'b1, 5'd5, 2'd0,
                           32'h22, 32'hbbbb, 32'hbbbb));
        #1;
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_m_not_ready: got %h expected %h", obs, exp);
        end
        $display("fwd M not ready: E_A=%h", obs.a);

        // rt forwarding from M, rs from register file
        bus.M_A3 = 5'd4; bus.M_Tnew = 2'd0; bus.M_WD = 32'h44;
        bus.W_A3 = 5'd9;
        exp_q.push_back(mk(32'h3010, 32'h0064_2800, 5'd2, 1'b1, 5'd5, 2'd0,
                           32'haaaa, 32'h44, 32'h44));
        #1;
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_rt_m: got %h expected %h", obs, exp);
        end
        $display("fwd rt from M: E_A=%h E_B=%h E_RT=%h", obs.a, obs.b, obs.rt);
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        eobs_t obs, exp;
        // rs=0, rt=0, funct=0x20
        bus.en = 1'b1;
        drive_d(32'h0000_3014, 32'h0000_0020, 32'h0, 32'h0, 32'h0,
                5'd2, 1'b0, 1'b1, 5'd6, 2'd1);
        tick();
        bus.en = 1'b0;
        bus.M_A3 = 5'd0; bus.M_RegWrite = 1'b1; bus.M_Tnew = 2'd0; bus.M_WD = 32'hffff;
        bus.W_A3 = 5'd0; bus.W_RegWrite = 1'b1; bus.W_WD = 32'h1234;
        exp_q.push_back(mk(32'h3014, 32'h0000_0020, 5'd2, 1'b1, 5'd6, 2'd0,
                           32'h0, 32'h0, 32'h0));
        #1;
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL zero_reg: got %h expected %h", obs, exp);
        end
        $display("reg $0 with M/W targeting $0: E_A=%h E_RT=%h", obs.a, obs.rt);
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        eobs_t obs, exp;
        bus.en = 1'b1;
        drive_d(32'h0000_3018, 32'h0085_3025, 32'h3, 32'h4, 32'h0,
                5'd1, 1'b0, 1'b1, 5'd6, 2'd2);
        tick();
        // reset beats clr and en; the fresh D instruction is dropped
        drive_d(32'h0000_301c, 32'h00a6_3824, 32'h5, 32'h6, 32'h0,
                5'd0, 1'b0, 1'b1, 5'd7, 2'd2);
        reset = 1'b1; bus.clr = 1'b1;
        exp_q.push_back(mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_clr_en: got %h expected %h", obs, exp);
        end
        $display("reset+clr+en: E_PC=%h", obs.pc);
        reset = 1'b0; bus.clr = 1'b0;

        exp_q.push_back(mk(32'h301c, 32'h00a6_3824, 5'd0, 1'b1, 5'd7, 2'd1,
                           32'h5, 32'h6, 32'h6));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reload_after_reset: got %h expected %h", obs, exp);
        end

        bus.en = 1'b0; bus.clr = 1'b1;
        exp_q.push_back(mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0));
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clr_over_hold: got %h expected %h", obs, exp);
        end
        $display("clr with en=0: E_PC=%h E_RegWrite=%b", obs.pc, obs.regwrite);
        bus.clr = 1'b0;
    endtask

    task automatic test_tnew_sat();
        eobs_t obs, exp;
        bus.en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            drive_d(32'h0000_3020 + 32'(t * 4), 32'h0000_0000, 32'h0, 32'h0, 32'h0,
                    5'd0, 1'b0, 1'b1, 5'd8, 2'(t));
            exp_q.push_back(mk(32'h3020 + 32'(t * 4), 32'h0, 5'd0, 1'b1, 5'd8, 2'd0,
                               32'h0, 32'h0, 32'h0));
            tick();
            obs = sample(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL tnew_sat%0d: got %h expected %h", t, obs, exp);
            end
            $display("D_Tnew=%0d -> E_Tnew=%0d", t, obs.tnew);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_back_to_back();
        eobs_t obs, exp, cur;
        logic [31:0] rd2_v;
        logic        alusrc_v;
        logic [31:0] ext_v;
        // start from a known bubble
        bus.clr = 1'b1;
        cur = mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(cur);
        tick();
        obs = sample(); exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_start: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 24; i++) begin
            bus.en  = ($urandom_range(0, 3) != 0);
            bus.clr = ($urandom_range(0, 7) == 0);
            rd2_v    = $urandom;
            alusrc_v = 1'($urandom);
            ext_v    = $urandom;
            drive_d($urandom, $urandom, $urandom, rd2_v, ext_v, 5'($urandom),
                    alusrc_v, 1'($urandom), 5'($urandom), 2'($urandom));
            if (bus.clr) begin
                cur = mk(BUBBLE_PC, 32'h0, 5'd0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0);
            end else if (bus.en) begin
                cur = mk(bus.D_PC, bus.D_Instr, bus.D_ALUOp, bus.D_RegWrite, bus.D_A3,
                         (bus.D_Tnew == 2'd0) ? 2'd0 : bus.D_Tnew - 2'd1,
                         bus.D_RD1, alusrc_v ? ext_v : rd2_v, rd2_v);
            end
            exp_q.push_back(cur);
            tick();
            obs = sample(); exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b%0d: got %h expected %h", i, obs, exp);
            end
            $display("b2b %0d en=%b clr=%b E_PC=%h E_Instr=%h",
                     i, bus.en, bus.clr, obs.pc, obs.instr);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_stall();
        test_forward();
        test_zero_reg();
        test_simultaneous();
        test_tnew_sat();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_e_reg.md
D_E_REG -- requirements
Module: D_E_REG

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC value held by a bubble or by reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: en  in  1  load enable (0 = hold); clr  in  1  insert bubble.
REQ-004 SHALL have ports: D_PC  in  32  PC; D_Instr  in  32  instruction; D_RD1, D_RD2  in  32 each  register-file read data; D_EXT  in  32  extended immediate.
REQ-005 SHALL have ports: D_ALUOp  in  5  ALU operation code; D_ALUSrc  in  1  ALU B source (1 = immediate); D_RegWrite  in  1  write enable; D_A3  in  5  destination register; D_Tnew  in  2  cycles until result is ready, counted from D.
REQ-006 SHALL have ports: M_A3  in  5; M_RegWrite  in  1; M_Tnew  in  2; M_WD  in  32 (forwarding source, M stage). W_A3  in  5; W_RegWrite  in  1; W_WD  in  32 (forwarding source, W stage).
REQ-007 SHALL have ports: E_PC, E_Instr  out  32 each; E_ALUOp  out  5; E_RegWrite  out  1; E_A3  out  5; E_Tnew  out  2.
REQ-008 SHALL have ports: E_A, E_B  out  32 each  ALU operands; E_RT  out  32  forwarded rt value carried to M for store data.

Function
REQ-009 SHALL register every D_* input on the rising clk edge when en=1 and clr=0.
REQ-010 SHALL keep all registered fields unchanged when en=0 and clr=0.
REQ-011 SHALL load a bubble when clr=1, regardless of en: Instr=0, RegWrite=0, A3=0, Tnew=0, ALUOp=0, ALUSrc=0, all data fields=0, PC=RESET_PC.
REQ-012 SHALL store Tnew as (D_Tnew==0 ? 0 : D_Tnew-1) when loading; this saturates at 0 and never wraps.
REQ-013 SHALL decode rs = Instr[25:21] and rt = Instr[20:16] from the registered instruction.
REQ-014 SHALL forward rs combinationally with priority M over W over register: take M_WD if M_RegWrite, M_A3==rs, rs!=0 and M_Tnew==0; otherwise take W_WD if W_RegWrite, W_A3==rs and rs!=0; otherwise take the registered RD1. The same rule SHALL apply to rt with RD2.
REQ-015 SHALL drive E_A = forwarded rs, E_RT = forwarded rt, and E_B = registered EXT when ALUSrc=1, else forwarded rt.
REQ-016 SHALL never forward when the register number is 0, so that operand values of 0 stay 0.
REQ-017 SHALL drive E_PC, E_Instr, E_ALUOp, E_RegWrite, E_A3 and E_Tnew directly from the register, with a latency of 1 cycle from D to E.
REQ-018 SHALL treat a W_WD that the hazard unit leaves stale (M_Tnew>0 with a matching A3) as a stall case handled upstream; the block SHALL NOT detect that case itself.

Reset
REQ-019 SHALL apply reset on the clock edge with priority reset > clr > hold > load.
REQ-020 SHALL, on reset, load the same values as a bubble (REQ-011), giving E_PC=RESET_PC and all other outputs 0 when no forwarding is active.
REQ-021 SHALL, when reset is asserted mid-stream, drop any in-flight instruction on that edge.

Structure
REQ-022 SHALL take the ALUOp encodings (AND=0, OR=1, ADD=2, SUB=3), the Tnew width and RESET_PC from the shared pipeline constants package.
REQ-023 SHALL contain one sub-module, E_FWD_MUX, instantiated twice (once for rs, once for rt), implementing REQ-014.

Verification
REQ-024 Load: en=1, D_PC=0x3004, D_Instr=0x34220005 (ori), D_EXT=5, D_ALUSrc=1, D_Tnew=2 -> next cycle E_PC=0x3004, E_B=5, E_Tnew=1.
REQ-025 Stall: en=0 for 3 cycles with D_* changing -> E_* outputs stay constant; after that, clr=1 -> E_Instr=0, E_RegWrite=0, E_PC=0x3000.
REQ-026 Forward priority: rs=3 in E, M_A3=3, M_RegWrite=1, M_Tnew=0, M_WD=0x11, W_A3=3, W_RegWrite=1, W_WD=0x22 -> E_A=0x11; then M_RegWrite=0 -> E_A=0x22.
REQ-027 Register $0: rs=0 with M_A3=0, M_RegWrite=1, M_WD=0xFFFF -> E_A equals the registered RD1 (0).
REQ-028 Simultaneous events: reset=1 with clr=1 and en=1 -> bubble with E_PC=RESET_PC; clr=1 with en=0 -> bubble (clr wins over hold).
REQ-029 Tnew saturation: D_Tnew=0 loaded -> E_Tnew=0, not 3.
